// File: rtl/cnt_seq_monitor.sv
// cnt_seq_monitor
//   Passive checker for a synchronous up/down counter. Each enabled cycle it samples the
//   counter command and value. It predicts the next value from the previous sample and flags
//   any sequence violation. It also counts wrap-around events. It never drives the counter.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset (overrides en and clr_err)
//   en              monitor enable
//   sel             counter command: 00 hold, 01 up, 10 down, 11 up
//   cnt_in          observed counter value
//   clr_err         synchronous clear of err_sticky / err_count
//   err_pulse       one-cycle flag: sample mismatched prediction
//   err_sticky      set on any error, held until clr_err or rst
//   err_count       saturating error count
//   wrap_up_pulse   one-cycle flag: max->0 under an up command
//   wrap_down_pulse one-cycle flag: 0->max under a down command
//   wrap_count      total wrap events, wraps naturally
//   tracking        high while the monitor is actively checking
module cnt_seq_monitor #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned ERR_W  = 8,
   parameter int unsigned WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        sel,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              clr_err,
   output logic              err_pulse,
   output logic              err_sticky,
   output logic [ERR_W-1:0]  err_count,
   output logic              wrap_up_pulse,
   output logic              wrap_down_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              tracking
);

   typedef enum logic [1:0] {StIdle, StArm, StCheck} state_e;

   localparam logic [WIDTH-1:0] CntMax = '1;
   localparam logic [ERR_W-1:0] ErrMax = '1;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  ref_cnt_q, ref_cnt_d;
   logic [1:0]        ref_sel_q, ref_sel_d;
   logic              err_pulse_q, err_pulse_d;
   logic              err_sticky_q, err_sticky_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic              wrap_up_q, wrap_up_d;
   logic              wrap_down_q, wrap_down_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

   logic              ref_up, ref_down;
   logic [WIDTH-1:0]  predicted;
   logic              do_check;
   logic              mismatch;

   // Expected value of this sample, from the previous sample and its command
   always_comb begin
      ref_up    = (ref_sel_q == 2'b01) || (ref_sel_q == 2'b11);
      ref_down  = (ref_sel_q == 2'b10);
      predicted = ref_cnt_q;
      if (ref_up) begin
         predicted = ref_cnt_q + WIDTH'(1);
      end else if (ref_down) begin
         predicted = ref_cnt_q - WIDTH'(1);
      end
   end

   // FSM next state and reference reload
   always_comb begin
      state_d   = state_q;
      ref_cnt_d = ref_cnt_q;
      ref_sel_d = ref_sel_q;
      do_check  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StArm;
            end
         end
         StArm: begin
            ref_cnt_d = cnt_in;
            ref_sel_d = sel;
            state_d   = en ? StCheck : StIdle;
         end
         StCheck: begin
            if (en) begin
               do_check = 1'b1;
               // Always resync to the observed value so one glitch yields one error
               ref_cnt_d = cnt_in;
               ref_sel_d = sel;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Flags and counters
   always_comb begin
      mismatch     = do_check && (cnt_in != predicted);
      err_pulse_d  = mismatch;
      wrap_up_d    = do_check && !mismatch && ref_up && (ref_cnt_q == CntMax) &&
                     (cnt_in == '0);
      wrap_down_d  = do_check && !mismatch && ref_down && (ref_cnt_q == '0) &&
                     (cnt_in == CntMax);
      wrap_count_d = wrap_count_q + WRAP_W'(wrap_up_d | wrap_down_d);

      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      if (clr_err) begin
         // A coincident error survives the clear
         err_sticky_d = mismatch;
         err_count_d  = mismatch ? ERR_W'(1) : '0;
      end else if (mismatch) begin
         err_sticky_d = 1'b1;
         if (err_count_q != ErrMax) begin
            err_count_d = err_count_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ref_cnt_q    <= '0;
         ref_sel_q    <= 2'b00;
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
         wrap_up_q    <= 1'b0;
         wrap_down_q  <= 1'b0;
         wrap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ref_cnt_q    <= ref_cnt_d;
         ref_sel_q    <= ref_sel_d;
         err_pulse_q  <= err_pulse_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
         wrap_up_q    <= wrap_up_d;
         wrap_down_q  <= wrap_down_d;
         wrap_count_q <= wrap_count_d;
      end
   end

   assign err_pulse       = err_pulse_q;
   assign err_sticky      = err_sticky_q;
   assign err_count       = err_count_q;
   assign wrap_up_pulse   = wrap_up_q;
   assign wrap_down_pulse = wrap_down_q;
   assign wrap_count      = wrap_count_q;
   assign tracking        = (state_q == StCheck);

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Self-checking bench for cnt_seq_monitor (WIDTH=4, ERR_W=2 to reach saturation quickly).
// A behavioural model predicts every output each cycle, and literal checks pin key points.
module tb_cnt_seq_monitor;

   localparam int WIDTH  = 4;
   localparam int ERR_W  = 2;
   localparam int WRAP_W = 8;
   localparam int MOD    = 1 << WIDTH;
   localparam int MAXV   = MOD - 1;
   localparam int ERRMAX = (1 << ERR_W) - 1;

   logic              clk;
   logic              rst;
   logic              en;
   logic [1:0]        sel;
   logic [WIDTH-1:0]  cnt_in;
   logic              clr_err;
   logic              err_pulse;
   logic              err_sticky;
   logic [ERR_W-1:0]  err_count;
   logic              wrap_up_pulse;
   logic              wrap_down_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic              tracking;

   int vectors    = 0;
   int miscompares = 0;
   bit chk_on     = 1'b0;

   cnt_seq_monitor #(
      .WIDTH  (WIDTH),
      .ERR_W  (ERR_W),
      .WRAP_W (WRAP_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .sel             (sel),
      .cnt_in          (cnt_in),
      .clr_err         (clr_err),
      .err_pulse       (err_pulse),
      .err_sticky      (err_sticky),
      .err_count       (err_count),
      .wrap_up_pulse   (wrap_up_pulse),
      .wrap_down_pulse (wrap_down_pulse),
      .wrap_count      (wrap_count),
      .tracking        (tracking)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // run = consecutive enabled edges since reset/disable (capped at 2):
   // 0 -> not sampling, 1 -> first sample pending capture, 2 -> checking.
   int m_run = 0, m_prev = 0, m_prev_sel = 0;
   int m_pulse = 0, m_sticky = 0, m_cnt = 0, m_wu = 0, m_wd = 0, m_wc = 0, m_track = 0;

   function automatic int predict(input int p, input int s);
      int d;
      d = (s == 0) ? 0 : ((s == 2) ? MAXV : 1);
      return (p + d) % MOD;
   endfunction

   always @(posedge clk) begin
      int run, prev, psel, cnt, st, wc, bad, wu, wd;
      bit chk, cap;
      run = m_run; prev = m_prev; psel = m_prev_sel;
      cnt = m_cnt; st = m_sticky; wc = m_wc;
      bad = 0; wu = 0; wd = 0;
      if (rst) begin
         run = 0; prev = 0; psel = 0; cnt = 0; st = 0; wc = 0;
      end else begin
         chk = (run >= 2) && en;
         cap = (run == 1) || chk;
         if (chk) begin
            bad = (int'(cnt_in) != predict(prev, psel)) ? 1 : 0;
            wu  = (!bad && (psel == 1 || psel == 3) && prev == MAXV && cnt_in == 0) ? 1 : 0;
            wd  = (!bad && psel == 2 && prev == 0 && cnt_in == MAXV) ? 1 : 0;
         end
         if (cap) begin
            prev = int'(cnt_in);
            psel = int'(sel);
         end
         if (clr_err) begin
            cnt = bad; st = bad;
         end else if (bad != 0) begin
            st = 1;
            if (cnt < ERRMAX) cnt = cnt + 1;
         end
         wc  = (wc + wu + wd) % (1 << WRAP_W);
         run = en ? ((run < 2) ? run + 1 : 2) : 0;
      end
      m_run <= run; m_prev <= prev; m_prev_sel <= psel;
      m_pulse <= bad; m_sticky <= st; m_cnt <= cnt;
      m_wu <= wu; m_wd <= wd; m_wc <= wc; m_track <= (run >= 2) ? 1 : 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("m.err_pulse", 32'(err_pulse), 32'(m_pulse));
         check("m.err_sticky", 32'(err_sticky), 32'(m_sticky));
         check("m.err_count", 32'(err_count), 32'(m_cnt));
         check("m.wrap_up", 32'(wrap_up_pulse), 32'(m_wu));
         check("m.wrap_down", 32'(wrap_down_pulse), 32'(m_wd));
         check("m.wrap_count", 32'(wrap_count), 32'(m_wc));
         check("m.tracking", 32'(tracking), 32'(m_track));
      end
   end

   // Apply one sample; returns just after the edge that samples it
   task automatic drive(input logic r, input logic e, input logic [1:0] s,
                        input int c, input logic cl);
      @(negedge clk);
      rst = r; en = e; sel = s; cnt_in = WIDTH'(c); clr_err = cl;
      @(posedge clk);
      #1;
   endtask

   int sat_v[9] = '{3, 3, 9, 9, 1, 1, 6, 6, 2};
   int sat_c[9] = '{1, 1, 2, 2, 3, 3, 3, 3, 3};

   initial begin
      rst = 1'b1; en = 1'b0; sel = 2'b00; cnt_in = '0; clr_err = 1'b0;

      // Reset
      drive(1, 0, 2'b00, 0, 0);
      drive(1, 0, 2'b00, 0, 0);
      chk_on = 1'b1;
      check("rst.err_count", 32'(err_count), 0);
      check("rst.wrap_count", 32'(wrap_count), 0);
      check("rst.tracking", 32'(tracking), 0);

      // Count up through a wrap
      for (int i = 0; i < 18; i++) begin
         drive(0, 1, 2'b01, i % 16, 0);
         if (i == 0) check("up.tracking_arm", 32'(tracking), 0);
         if (i == 1) check("up.tracking_on", 32'(tracking), 1);
         if (i == 16) begin
            check("up.wrap_pulse", 32'(wrap_up_pulse), 1);
            check("up.wrap_count", 32'(wrap_count), 1);
         end
      end
      check("up.err_count", 32'(err_count), 0);

      // Count down through a wrap (re-arm first)
      drive(0, 0, 2'b10, 3, 0);
      foreach (sat_v[i]) begin end
      drive(0, 1, 2'b10, 3, 0);
      drive(0, 1, 2'b10, 2, 0);
      drive(0, 1, 2'b10, 1, 0);
      drive(0, 1, 2'b10, 0, 0);
      drive(0, 1, 2'b10, 15, 0);
      check("dn.wrap_pulse", 32'(wrap_down_pulse), 1);
      check("dn.wrap_count", 32'(wrap_count), 2);
      drive(0, 1, 2'b10, 14, 0);
      check("dn.err_sticky", 32'(err_sticky), 0);

      // Glitch: 4,5,9,10,11 -> one error at 9
      drive(0, 0, 2'b01, 4, 0);
      drive(0, 1, 2'b01, 4, 0);
      drive(0, 1, 2'b01, 5, 0);
      drive(0, 1, 2'b01, 9, 0);
      check("glitch.err_pulse", 32'(err_pulse), 1);
      check("glitch.err_count", 32'(err_count), 1);
      drive(0, 1, 2'b01, 10, 0);
      check("glitch.resync", 32'(err_pulse), 0);
      drive(0, 1, 2'b01, 11, 0);
      check("glitch.err_sticky", 32'(err_sticky), 1);

      // Hold at 7, then an illegal step to 8
      drive(0, 0, 2'b00, 7, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 2'b00, 7, 0);
      check("hold.no_err", 32'(err_count), 1);
      drive(0, 1, 2'b00, 8, 0);
      check("hold.err_count", 32'(err_count), 2);

      // clr_err alone
      drive(0, 1, 2'b00, 8, 1);
      check("clr.err_count", 32'(err_count), 0);
      check("clr.err_sticky", 32'(err_sticky), 0);

      // Saturation: five separate mismatches
      foreach (sat_v[i]) begin
         drive(0, 1, 2'b00, sat_v[i], 0);
         check("sat.err_count", 32'(err_count), 32'(sat_c[i]));
      end
      check("sat.err_sticky", 32'(err_sticky), 1);

      // clr_err coincident with a mismatch
      drive(0, 1, 2'b00, 5, 1);
      check("clr_err.err_count", 32'(err_count), 1);
      check("clr_err.err_sticky", 32'(err_sticky), 1);
      check("clr_err.err_pulse", 32'(err_pulse), 1);

      // sel=11 counts as up
      drive(0, 0, 2'b11, 13, 0);
      drive(0, 1, 2'b11, 13, 0);
      drive(0, 1, 2'b11, 14, 0);
      drive(0, 1, 2'b11, 15, 0);
      drive(0, 1, 2'b11, 0, 0);
      check("s11.wrap_pulse", 32'(wrap_up_pulse), 1);
      check("s11.err_pulse", 32'(err_pulse), 0);
      check("s11.wrap_count", 32'(wrap_count), 3);

      // Mid-run reset overrides en and clr_err
      drive(1, 1, 2'b11, 1, 1);
      check("mrst.err_count", 32'(err_count), 0);
      check("mrst.err_sticky", 32'(err_sticky), 0);
      check("mrst.wrap_count", 32'(wrap_count), 0);
      check("mrst.tracking", 32'(tracking), 0);
      drive(0, 1, 2'b01, 3, 0);
      drive(0, 1, 2'b01, 4, 0);
      drive(0, 1, 2'b01, 5, 0);
      check("mrst.tracking_back", 32'(tracking), 1);

      // Disabled while the counter jumps, then re-arm
      drive(0, 0, 2'b01, 5, 0);
      check("dis.tracking", 32'(tracking), 0);
      drive(0, 0, 2'b01, 12, 0);
      drive(0, 0, 2'b01, 12, 0);
      drive(0, 1, 2'b01, 12, 0);
      drive(0, 1, 2'b01, 13, 0);
      drive(0, 1, 2'b01, 14, 0);
      check("rearm.err_count", 32'(err_count), 0);
      check("rearm.err_sticky", 32'(err_sticky), 0);
      check("rearm.tracking", 32'(tracking), 1);

      @(negedge clk);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cnt_seq_monitor.md
Name: cnt_seq_monitor

Overview:
Downstream checker for the synchronous up/down counter. Each cycle it samples the counter's `sel` command and its `out_updown` value, and predicts the next count from the previous sample. It flags any sequence violation and tracks wrap-around events. It sits beside the counter in the integration bench and in silicon debug logic; it never drives the counter.

Parameters:
WIDTH, 4, counter width; prediction is modulo 2^WIDTH
ERR_W, 8, width of saturating error counter
WRAP_W, 8, width of wrap-event counter (wraps naturally modulo 2^WRAP_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  monitor enable
sel  input  2  counter command: 00 hold, 01 up, 10 down, 11 up
cnt_in  input  WIDTH  counter value (`out_updown`) under observation
clr_err  input  1  synchronous clear of err_sticky and err_count
err_pulse  output  1  one-cycle flag: sampled value mismatched prediction
err_sticky  output  1  set on any error, held until clr_err or rst
err_count  output  ERR_W  number of errors, saturating at all-ones
wrap_up_pulse  output  1  one-cycle flag: max->0 transition under up command
wrap_down_pulse  output  1  one-cycle flag: 0->max transition under down command
wrap_count  output  WRAP_W  total wrap events (up + down)
tracking  output  1  high while FSM in CHECK

Behaviour:
- Reset (rst=1 at edge): all outputs 0, FSM -> IDLE, ref_cnt=0, ref_sel=00. rst overrides en and clr_err.
- The counter is registered. Its value at sample k+1 must equal step(ref_cnt, ref_sel), where ref_cnt and ref_sel are the sample-k values.
- step rules:
  - 00 -> same value.
  - 01 or 11 -> +1 mod 2^WIDTH.
  - 10 -> -1 mod 2^WIDTH.
- FSM, three states:
  - IDLE: en=0, or just out of reset. Pulses 0; counters and sticky hold. en=1 -> ARM.
  - ARM: capture ref_cnt<=cnt_in and ref_sel<=sel; no check. Next -> CHECK if en=1, else IDLE.
  - CHECK: compare cnt_in with step(ref_cnt, ref_sel), then always reload ref_cnt<=cnt_in and ref_sel<=sel. This resync means a single glitch yields one error, not a stream. en=0 -> IDLE at that edge, and no check is performed in that cycle.
- Latency: all flags are registered. A pulse is asserted in the cycle after the offending sample edge and lasts exactly one cycle.
- Error handling:
  - Mismatch in CHECK -> err_pulse=1, err_sticky=1.
  - err_count+1, saturating at 2^ERR_W-1 with no wrap.
- Wrap detection (CHECK only, prediction must match):
  - ref_cnt=max, ref_sel up, cnt_in=0 -> wrap_up_pulse.
  - ref_cnt=0, ref_sel=10, cnt_in=max -> wrap_down_pulse.
  - Each wrap event increments wrap_count.
  - A mismatching sample never produces a wrap pulse.
- clr_err=1:
  - Clears err_sticky and err_count at that edge.
  - If an error is detected in the same cycle, the new error is recorded: err_count=1, err_sticky=1, err_pulse=1.
  - Does not affect wrap_count or the FSM.
- sel changes are legal on any cycle. The command sampled with value k governs the k+1 prediction.
- Mid-operation rst: next cycle all outputs 0 and FSM IDLE; one ARM cycle follows before checking resumes.
- tracking=1 exactly when the registered state is CHECK.

Test Plan:
- Count-up wrap: rst 2 cycles; en=1, sel=01, cnt_in 0,1,...,15,0,1 -> err_pulse never 1; one wrap_up_pulse the cycle after cnt_in=0 is sampled; wrap_count=1; tracking=1 from the third cycle after en.
- Count-down wrap: en=1, sel=10, cnt_in 3,2,1,0,15,14 -> one wrap_down_pulse after 15 is sampled; wrap_count increments by 1; no errors.
- Glitch and hold: sel=01 with cnt_in 4,5,9,10,11 -> single err_pulse after 9 only, err_count=1, err_sticky=1. Then sel=00 with cnt_in held at 7 for 5 cycles, then 8 -> no error during hold (after resync at 7), one error at 8, err_count=2.
- Saturation with ERR_W=2: inject 5 separate mismatches -> err_count sequence 1,2,3,3,3 and err_sticky stays 1.
- clr_err interplay: with err_count=3, clr_err alone -> err_count=0, sticky=0. clr_err coincident with a mismatch -> err_count=1, sticky=1, err_pulse=1.
- sel=11 and reset/enable: sel=11 with cnt_in 14,15,0 -> counts as up, wrap_up_pulse, no error. rst mid-run -> all outputs 0 next cycle; en dropped for 3 cycles while cnt_in jumps 5->12 -> no error, and re-arming on en rise gives no false error.
